// File: rtl/seg7_scan_to_bcd_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_to_bcd_if
// Brief    : Multiplexed 7-segment scan bus plus the decoded frame outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_to_bcd_if #(
    parameter int NDIG = 4
);
    logic [NDIG-1:0]   dig_sel;
    logic [6:0]        seg;
    logic [4*NDIG-1:0] bcd_out;
    logic              frame_valid;
    logic              frame_err;

    modport master (
        output dig_sel,
        output seg,
        input  bcd_out,
        input  frame_valid,
        input  frame_err
    );

    modport slave (
        input  dig_sel,
        input  seg,
        output bcd_out,
        output frame_valid,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_to_bcd
// Brief    : Converts a scanned N-digit 7-segment bus back into a BCD frame.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_to_bcd #(
    parameter int NDIG   = 4,
    parameter int SETTLE = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    seg7_scan_to_bcd_if.slave bus
);

    localparam logic [7:0]      c_settle    = 8'(SETTLE);
    localparam logic [7:0]      c_settle_m1 = 8'(SETTLE - 1);
    localparam logic [NDIG-1:0] c_one       = {{(NDIG-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_ACQ     = 1'b0,
        ST_PUBLISH = 1'b1
    } state_t;

    state_t            state_q;
    logic [NDIG-1:0]   sel_q;
    logic [6:0]        seg_q;
    logic [7:0]        cnt_q;
    logic [NDIG-1:0]   mask_q;
    logic [NDIG-1:0]   inv_q;
    logic [4*NDIG-1:0] digits_q;
    logic [4*NDIG-1:0] bcd_out_q;
    logic              frame_valid_q;
    logic              frame_err_q;

    logic [NDIG-1:0]   w_sel;
    logic [6:0]        w_seg;
    logic              w_onehot;
    logic              w_changed;
    logic              w_capture;
    logic [3:0]        w_dec;
    logic              w_bad;
    logic [NDIG-1:0]   w_mask_d;
    logic [NDIG-1:0]   w_inv_d;

    assign w_sel = bus.dig_sel;
    assign w_seg = bus.seg;

    always_comb begin
        w_onehot  = (w_sel != '0) && ((w_sel & (w_sel - c_one)) == '0);
        w_changed = (w_sel != sel_q) || (w_seg != seg_q);
        // The SETTLE-th consecutive identical edge; cnt then saturates so one dwell captures once.
        w_capture = w_onehot && !w_changed && (cnt_q == c_settle_m1);
        w_mask_d  = mask_q | w_sel;
        w_inv_d   = (inv_q & ~w_sel) | (w_bad ? w_sel : '0);
    end

    always_comb begin
        w_dec = 4'hE;
        w_bad = 1'b1;
        case (w_seg)
            7'h7E:   begin w_dec = 4'h0; w_bad = 1'b0; end
            7'h30:   begin w_dec = 4'h1; w_bad = 1'b0; end
            7'h6D:   begin w_dec = 4'h2; w_bad = 1'b0; end
            7'h79:   begin w_dec = 4'h3; w_bad = 1'b0; end
            7'h33:   begin w_dec = 4'h4; w_bad = 1'b0; end
            7'h5B:   begin w_dec = 4'h5; w_bad = 1'b0; end
            7'h5F:   begin w_dec = 4'h6; w_bad = 1'b0; end
            7'h70:   begin w_dec = 4'h7; w_bad = 1'b0; end
            7'h7F:   begin w_dec = 4'h8; w_bad = 1'b0; end
            7'h7B:   begin w_dec = 4'h9; w_bad = 1'b0; end
            7'h00:   begin w_dec = 4'hF; w_bad = 1'b0; end
            default: begin w_dec = 4'hE; w_bad = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ACQ;
            sel_q         <= '0;
            seg_q         <= '0;
            cnt_q         <= '0;
            mask_q        <= '0;
            inv_q         <= '0;
            digits_q      <= '0;
            bcd_out_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sel_q         <= w_sel;
            seg_q         <= w_seg;

            if (!w_onehot) begin
                cnt_q <= '0;
            end else if (w_changed) begin
                cnt_q <= 8'd1;
            end else if (cnt_q < c_settle) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (w_capture) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (w_sel[i]) begin
                        digits_q[4*i +: 4] <= w_dec;
                    end
                end
            end

            case (state_q)
                ST_ACQ: begin
                    if (w_capture) begin
                        mask_q <= w_mask_d;
                        inv_q  <= w_inv_d;
                        if (&w_mask_d) begin
                            state_q <= ST_PUBLISH;
                        end
                    end
                end
                ST_PUBLISH: begin
                    // bcd_out reads the pre-edge store, so a coincident capture only seeds the next frame.
                    bcd_out_q     <= digits_q;
                    frame_err_q   <= |inv_q;
                    frame_valid_q <= 1'b1;
                    mask_q        <= w_capture ? w_sel : '0;
                    inv_q         <= (w_capture && w_bad) ? w_sel : '0;
                    state_q       <= ST_ACQ;
                end
                default: state_q <= ST_ACQ;
            endcase
        end
    end

    assign bus.bcd_out     = bcd_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_to_bcd
// Brief    : Scoreboard bench for seg7_scan_to_bcd (NDIG=4, SETTLE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_to_bcd;

    typedef struct packed {
        logic [15:0] bcd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    seg7_scan_to_bcd_if #(.NDIG(4)) bus ();

    seg7_scan_to_bcd #(.NDIG(4), .SETTLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] sg, input int n);
        @(negedge clk);
        bus.dig_sel = sel;
        bus.seg     = sg;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic idle_and_drain(input string name);
        hold(4'b0000, 7'h00, 4);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every published frame must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.frame_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'(bus.bcd_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_bcd", 32'(bus.bcd_out), 32'(e.bcd));
                chk("frame_err", 32'(bus.frame_err), 32'(e.err));
            end
        end
    end

    initial begin
        bus.dig_sel = '0;
        bus.seg     = '0;
        repeat (3) @(negedge clk);
        chk("reset_bcd", 32'(bus.bcd_out), 32'd0);
        chk("reset_valid", 32'(bus.frame_valid), 32'd0);
        chk("reset_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;

        // 1: clean scan 0..3
        exp_q.push_back('{bcd: 16'h3210, err: 1'b0});
        hold(4'b0001, 7'h7E, 6);
        hold(4'b0010, 7'h30, 6);
        hold(4'b0100, 7'h6D, 6);
        hold(4'b1000, 7'h79, 6);
        idle_and_drain("t1_drain");

        // 2: dwell one short of SETTLE never captures
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            hold(4'b0001, 7'h7E, 3);
            hold(4'b0010, 7'h30, 3);
            hold(4'b0100, 7'h6D, 3);
            hold(4'b1000, 7'h79, 3);
        end
        idle_and_drain("t2_drain");
        chk("t2_bcd_zero", 32'(bus.bcd_out), 32'd0);
        chk("t2_err_zero", 32'(bus.frame_err), 32'd0);

        // 3: invalid + blank digits, minimum dwell
        exp_q.push_back('{bcd: 16'hFE98, err: 1'b1});
        hold(4'b0001, 7'h7F, 4);
        hold(4'b0010, 7'h7B, 4);
        hold(4'b0100, 7'h01, 4);
        hold(4'b1000, 7'h00, 4);
        idle_and_drain("t3_drain");

        // 4: multi-hot select is ignored
        hold(4'b0011, 7'h7E, 10);
        exp_q.push_back('{bcd: 16'h7654, err: 1'b0});
        hold(4'b0001, 7'h33, 6);
        hold(4'b0010, 7'h5B, 6);
        hold(4'b0100, 7'h5F, 6);
        hold(4'b1000, 7'h70, 6);
        idle_and_drain("t4_drain");

        // 5: reset discards a partial frame
        hold(4'b0001, 7'h70, 6);
        hold(4'b0010, 7'h70, 6);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.dig_sel = '0;
        #1;
        chk("t5_rst_bcd", 32'(bus.bcd_out), 32'd0);
        chk("t5_rst_valid", 32'(bus.frame_valid), 32'd0);
        chk("t5_rst_err", 32'(bus.frame_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{bcd: 16'h0138, err: 1'b0});
        hold(4'b0100, 7'h30, 6);
        hold(4'b1000, 7'h7E, 6);
        hold(4'b0001, 7'h7F, 6);
        hold(4'b0010, 7'h79, 6);
        idle_and_drain("t5_drain");

        // 6: segment change mid-dwell restarts the settle count
        exp_q.push_back('{bcd: 16'h4326, err: 1'b0});
        hold(4'b0001, 7'h5B, 2);
        hold(4'b0001, 7'h5F, 4);
        hold(4'b0010, 7'h6D, 6);
        hold(4'b0100, 7'h79, 6);
        hold(4'b1000, 7'h33, 6);
        idle_and_drain("t6_drain");

        hold(4'b0000, 7'h00, 5);
        chk("hold_bcd", 32'(bus.bcd_out), 32'h4326);
        chk("hold_err", 32'(bus.frame_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
